// File: rtl/my_dmux_n_way_stream.sv
// Registered N-way stream demultiplexer, one output register per channel.
// Optional broadcast mode: define MY_DMUX_BCAST_EN to add the in_bcast port.
module my_dmux_n_way_stream #(
    parameter  int WIDTH = 8,
    parameter  int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
`ifdef MY_DMUX_BCAST_EN
    input  logic               in_bcast,
`endif
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [7:0]         drop_cnt
);

    logic [N-1:0]     r_valid;
    logic [WIDTH-1:0] r_data [N];
    logic [7:0]       r_drop;

    logic [N-1:0]     w_hit;
    logic [N-1:0]     w_full;
    logic [N-1:0]     w_load;
    logic             w_bcast;
    logic             w_ready;
    logic             w_xfer;
    logic             w_drop;

`ifdef MY_DMUX_BCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // An out-of-range select hits no channel, so it is never back-pressured.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N; i++) begin
            w_hit[i] = (in_sel == SEL_W'(i));
        end
    end

    assign w_full  = r_valid & ~out_ready;
    assign w_ready = w_bcast ? ~|w_full : ~|(w_hit & w_full);
    assign w_xfer  = in_valid & w_ready;
    assign w_drop  = w_xfer & ~w_bcast & ~|w_hit;

    always_comb begin
        w_load = '0;
        if (w_xfer) begin
            w_load = w_bcast ? '1 : w_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < N; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_load[i]) begin
                    r_data[i]  <= in_data;
                    r_valid[i] <= 1'b1;
                end else if (r_valid[i] && out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_drop && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

    assign in_ready  = w_ready;
    assign out_valid = r_valid;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_my_dmux_n_way_stream.sv
// Bench for my_dmux_n_way_stream: N=8 unit against a queue-free channel model,
// N=6 unit for drop counting, N=4 unit for broadcast when MY_DMUX_BCAST_EN.
module tb_my_dmux_n_way_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // N=8 unit
    logic        iv8 = 0;
    logic [7:0]  data8 = 0;
    logic [2:0]  sel8 = 0;
    logic [7:0]  ordy8 = 0;
    logic        rdy8;
    logic [7:0]  ov8;
    logic [63:0] od8;
    logic [7:0]  dc8;

    my_dmux_n_way_stream #(.WIDTH(8), .N(8)) d8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(rdy8),
        .in_data(data8), .in_sel(sel8),
`ifdef MY_DMUX_BCAST_EN
        .in_bcast(1'b0),
`endif
        .out_valid(ov8), .out_ready(ordy8),
        .out_data(od8), .drop_cnt(dc8)
    );

    // N=6 unit
    logic        iv6 = 0;
    logic [7:0]  data6 = 0;
    logic [2:0]  sel6 = 0;
    logic [5:0]  ordy6 = 0;
    logic        rdy6;
    logic [5:0]  ov6;
    logic [47:0] od6;
    logic [7:0]  dc6;

    my_dmux_n_way_stream #(.WIDTH(8), .N(6)) d6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv6), .in_ready(rdy6),
        .in_data(data6), .in_sel(sel6),
`ifdef MY_DMUX_BCAST_EN
        .in_bcast(1'b0),
`endif
        .out_valid(ov6), .out_ready(ordy6),
        .out_data(od6), .drop_cnt(dc6)
    );

`ifdef MY_DMUX_BCAST_EN
    logic        iv4 = 0;
    logic [7:0]  data4 = 0;
    logic [1:0]  sel4 = 0;
    logic        bc4 = 0;
    logic [3:0]  ordy4 = 0;
    logic        rdy4;
    logic [3:0]  ov4;
    logic [31:0] od4;
    logic [7:0]  dc4;

    my_dmux_n_way_stream #(.WIDTH(8), .N(4)) d4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(rdy4),
        .in_data(data4), .in_sel(sel4),
        .in_bcast(bc4),
        .out_valid(ov4), .out_ready(ordy4),
        .out_data(od4), .drop_cnt(dc4)
    );
`endif

    // Channel model for the N=8 unit: each channel is a one-word slot.
    logic [7:0] m_valid;
    logic [7:0] m_data [8];

    function automatic logic m_rdy();
        return (m_valid[sel8] == 1'b0) || ordy8[sel8];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic acc;
        if (!rst_n) begin
            m_valid = '0;
            for (int i = 0; i < 8; i++) m_data[i] = '0;
        end else begin
            acc = iv8 && m_rdy();
            for (int i = 0; i < 8; i++) begin
                if (acc && int'(sel8) == i) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = data8;
                end else if (m_valid[i] && ordy8[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_ready8", {63'd0, rdy8}, {63'd0, m_rdy()});
        chk("cmp_valid8", {56'd0, ov8}, {56'd0, m_valid});
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cmp_data8[%0d]", i),
                {56'd0, od8[i*8 +: 8]}, {56'd0, m_data[i]});
        end
        chk("cmp_drop8", {56'd0, dc8}, 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("reset_valid8", {56'd0, ov8}, 64'd0);
        chk("reset_data8", od8, 64'd0);
        chk("reset_drop6", {56'd0, dc6}, 64'd0);
        rst_n = 1'b1;
        step();

        // unicast sweep
        ordy8 = 8'hFF;
        iv8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data8 = 8'hA0 + 8'(i);
            sel8 = 3'(i);
            #1;
            chk("sweep_ready", {63'd0, rdy8}, 64'd1);
            step();
            chk("sweep_valid", {56'd0, ov8}, 64'd1 << i);
            chk("sweep_data", {56'd0, od8[i*8 +: 8]}, {56'd0, 8'hA0 + 8'(i)});
        end
        iv8 = 1'b0;
        step();
        chk("sweep_empty", {56'd0, ov8}, 64'd0);

        // back-pressure on ch3 only
        ordy8 = 8'hF7;
        iv8 = 1'b1;
        sel8 = 3'd3;
        data8 = 8'h55;
        step();
        data8 = 8'h99;
        #1;
        chk("bp_ready3", {63'd0, rdy8}, 64'd0);
        step();
        chk("bp_hold3", {56'd0, od8[24 +: 8]}, 64'h55);
        chk("bp_valid3", {63'd0, ov8[3]}, 64'd1);
        sel8 = 3'd5;
        data8 = 8'h66;
        #1;
        chk("bp_ready5", {63'd0, rdy8}, 64'd1);
        step();
        chk("bp_valid35", {56'd0, ov8}, 64'h28);
        chk("bp_data5", {56'd0, od8[40 +: 8]}, 64'h66);

        // drain and load on the same channel
        ordy8 = 8'hFF;
        sel8 = 3'd2;
        data8 = 8'h11;
        step();
        data8 = 8'h77;
        #1;
        chk("dl_ready", {63'd0, rdy8}, 64'd1);
        step();
        chk("dl_valid2", {63'd0, ov8[2]}, 64'd1);
        chk("dl_data2", {56'd0, od8[16 +: 8]}, 64'h77);
        iv8 = 1'b0;
        step();

        // async reset with every channel full
        ordy8 = 8'h00;
        iv8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel8 = 3'(i);
            data8 = 8'h30 + 8'(i);
            step();
        end
        iv8 = 1'b0;
        chk("full_valid", {56'd0, ov8}, 64'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {56'd0, ov8}, 64'd0);
        chk("async_data", od8, 64'd0);
        chk("async_drop", {56'd0, dc8}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // out-of-range select on N=6
        ordy6 = 6'h3F;
        iv6 = 1'b1;
        sel6 = 3'd7;
        for (int k = 0; k < 300; k++) begin
            data6 = 8'(k);
            #1;
            chk("drop_ready", {63'd0, rdy6}, 64'd1);
            step();
            if (k == 9) chk("drop_10", {56'd0, dc6}, 64'd10);
            if (k == 254) chk("drop_255", {56'd0, dc6}, 64'd255);
        end
        iv6 = 1'b0;
        step();
        chk("drop_sat", {56'd0, dc6}, 64'd255);
        chk("drop_valid", {56'd0, ov6}, 64'd0);

`ifdef MY_DMUX_BCAST_EN
        ordy4 = 4'b0000;
        iv4 = 1'b1;
        sel4 = 2'd0;
        data4 = 8'h12;
        step();
        bc4 = 1'b1;
        data4 = 8'hC3;
        ordy4 = 4'b1110;
        #1;
        chk("bc_ready0", {63'd0, rdy4}, 64'd0);
        step();
        chk("bc_hold", {60'd0, ov4}, 64'h1);
        ordy4 = 4'b1111;
        #1;
        chk("bc_ready1", {63'd0, rdy4}, 64'd1);
        step();
        chk("bc_valid", {60'd0, ov4}, 64'hF);
        chk("bc_data", {32'd0, od4}, 64'hC3C3C3C3);
        chk("bc_drop", {56'd0, dc4}, 64'd0);
        iv4 = 1'b0;
        bc4 = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
